// File: rtl/tt_io_stimulus_driver.sv
// -----------------------------------------------------------------------------
// tt_io_stimulus_driver
//
// Harness-side stimulus generator and response compressor for a TinyTapeout
// user module. On a start request it drives a generated user clock on
// io_in[0], holds the user reset on io_in[1] for RESET_CYCLES generated
// periods, then streams pseudo-random data on io_in[7:2] for NUM_CYCLES
// periods. The user module's io_out is folded into a 16-bit MISR on every
// data-advancing (falling) edge of the generated clock.
//
// Generated-clock period shape (P = 2*HALF_PERIOD clk cycles):
//   RST periods : high half, then low half  (user reset held high)
//   RUN periods : low half,  then high half (data valid around the rise)
// In RUN the period ends on the falling edge, which is where the MISR
// samples io_out and the data register advances. So data is stable for a
// full half period on each side of every rising edge.
//
// Parameters:
//   HALF_PERIOD  clk cycles per half period of the generated clock (>=1)
//   RESET_CYCLES generated periods with the user reset high          (>=1)
//   NUM_CYCLES   generated periods in the run phase                  (>=1)
//   SEED         initial data value (zero is replaced by 6'h01 for the LFSR)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   level; launches a run when sampled in IDLE or DONE
//   busy       out  high while the user reset or run phase is in progress
//   done       out  high once a run has completed
//   io_in      out  [0] user clock, [1] user reset, [7:2] data
//   io_out     in   response from the user module
//   signature  out  MISR contents (initial value 16'hFFFF)
//
// Build option:
//   TT_DRIVER_COUNTUP_EN  when defined, the data register is a 6-bit
//                         up-counter (SEED loaded as-is) instead of the LFSR.
// -----------------------------------------------------------------------------
module tt_io_stimulus_driver #(
    parameter int unsigned HALF_PERIOD  = 5,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned NUM_CYCLES   = 64,
    parameter logic [5:0]  SEED         = 6'h2D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  io_in,
    input  logic [7:0]  io_out,
    output logic [15:0] signature
);

    localparam int unsigned HC_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned MAX_PC = (RESET_CYCLES > NUM_CYCLES) ? RESET_CYCLES : NUM_CYCLES;
    localparam int unsigned PC_W   = (MAX_PC > 1) ? $clog2(MAX_PC) : 1;

    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HALF_PERIOD - 1);
    localparam logic [PC_W-1:0] RST_LAST = PC_W'(RESET_CYCLES - 1);
    localparam logic [PC_W-1:0] RUN_LAST = PC_W'(NUM_CYCLES - 1);

`ifdef TT_DRIVER_COUNTUP_EN
    localparam logic [5:0] SEED_EFF = SEED;
`else
    // An all-zero LFSR state would lock up, so substitute a non-zero seed.
    localparam logic [5:0] SEED_EFF = (SEED == 6'h00) ? 6'h01 : SEED;
`endif

    localparam logic [15:0] SIG_INIT = 16'hFFFF;
    localparam logic [15:0] SIG_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [HC_W-1:0] half_cnt_q,   half_cnt_d;
    logic            phase_q,      phase_d;       // 0: first half of period
    logic [PC_W-1:0] period_cnt_q, period_cnt_d;
    logic [5:0]      data_q,       data_d;
    logic [15:0]     sig_d;
    logic [7:0]      io_in_d;
    logic            busy_d, done_d;

    logic half_end;
    logic period_end;

    assign half_end   = (half_cnt_q == HC_LAST);
    assign period_end = half_end && phase_q;

    function automatic logic [5:0] next_data(input logic [5:0] d);
`ifdef TT_DRIVER_COUNTUP_EN
        return d + 6'd1;
`else
        return {d[4:0], d[5] ^ d[4]};
`endif
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] din);
        return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {8'h00, din};
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RST;
            end
            S_RST: begin
                if (period_end && (period_cnt_q == RST_LAST)) state_d = S_RUN;
            end
            S_RUN: begin
                if (period_end && (period_cnt_q == RUN_LAST)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values (all registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        half_cnt_d   = half_cnt_q;
        phase_d      = phase_q;
        period_cnt_d = period_cnt_q;
        data_d       = data_q;
        sig_d        = signature;
        io_in_d      = io_in;

        case (state_q)
            S_IDLE, S_DONE: begin
                io_in_d = 8'h00;
                if (start) begin
                    half_cnt_d   = '0;
                    phase_d      = 1'b0;
                    period_cnt_d = '0;
                    data_d       = SEED_EFF;
                    sig_d        = SIG_INIT;
                    io_in_d      = 8'h03;   // user clock high, user reset high
                end
            end

            S_RST, S_RUN: begin
                if (half_end) begin
                    half_cnt_d = '0;
                    phase_d    = ~phase_q;
                end else begin
                    half_cnt_d = half_cnt_q + HC_W'(1);
                end

                // Mid-period edge: the clock falls in RST, rises in RUN.
                if (half_end && !phase_q) begin
                    io_in_d[0] = (state_q == S_RUN);
                end

                if (period_end) begin
                    if (state_q == S_RST) begin
                        if (period_cnt_q == RST_LAST) begin
                            period_cnt_d = '0;
                            io_in_d      = {data_q, 2'b00};  // release reset, show seed
                        end else begin
                            period_cnt_d = period_cnt_q + PC_W'(1);
                            io_in_d[0]   = 1'b1;
                        end
                    end else begin
                        // Falling edge of a run period: capture and advance.
                        sig_d  = misr_step(signature, io_out);
                        data_d = next_data(data_q);
                        if (period_cnt_q == RUN_LAST) begin
                            period_cnt_d = '0;
                            io_in_d      = 8'h00;
                        end else begin
                            period_cnt_d = period_cnt_q + PC_W'(1);
                            io_in_d      = {data_d, 2'b00};
                        end
                    end
                end
            end

            default: io_in_d = 8'h00;
        endcase

        busy_d = (state_d == S_RST) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_cnt_q   <= '0;
            phase_q      <= 1'b0;
            period_cnt_q <= '0;
            data_q       <= SEED_EFF;
            signature    <= SIG_INIT;
            io_in        <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            half_cnt_q   <= half_cnt_d;
            phase_q      <= phase_d;
            period_cnt_q <= period_cnt_d;
            data_q       <= data_d;
            signature    <= sig_d;
            io_in        <= io_in_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule
